regfile_wb_scheduler: RTL and testbench

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

---
 rtl/regfile_wb_if.sv | 41 ++++
 rtl/regfile_wb_scheduler.sv | 109 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_if.sv
// Bundle of the write-back requester handshakes, reservation/hazard-check port
// and the registered register-file write port used by regfile_wb_scheduler.
interface regfile_wb_if;
  // Handshake: wbN_valid/wbN_ready; a beat transfers at a rising clk edge where both
  // are high, and ready never depends on valid.
  logic        wb0_valid;
  logic        wb0_ready;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb1_valid;
  logic        wb1_ready;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        rsv_valid;
  logic [4:0]  rsv_addr;
  logic [4:0]  chk_addrA;
  logic [4:0]  chk_addrB;
  logic        busy_A;
  logic        busy_B;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rsv_err;
  logic        dbg_rr_ptr;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    output wb1_valid, wb1_addr, wb1_data,
    output rsv_valid, rsv_addr, chk_addrA, chk_addrB,
    input  wb0_ready, wb1_ready, busy_A, busy_B,
    input  rf_we, rf_waddr, rf_wdata, rsv_err, dbg_rr_ptr
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    input  wb1_valid, wb1_addr, wb1_data,
    input  rsv_valid, rsv_addr, chk_addrA, chk_addrB,
    output wb0_ready, wb1_ready, busy_A, busy_B,
    output rf_we, rf_waddr, rf_wdata, rsv_err, dbg_rr_ptr
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Two-requester write-back scheduler: 1-entry slot per requester, round-robin
// arbitration onto a single registered regfile write port, plus a pending-write scoreboard.
module regfile_wb_scheduler (
    input logic         clk,
    input logic         reset,
    regfile_wb_if.slave bus
);

    logic        s0_v, s1_v;
    logic [4:0]  s0_a, s1_a;
    logic [31:0] s0_d, s1_d;
    logic        rr_ptr;
    logic [31:0] pending;
    logic [31:0] pending_nxt;
    logic        gnt0, gnt1, any_gnt;
    logic [4:0]  g_addr;
    logic [31:0] g_data;
    logic        take0, take1;
    logic        rsv_conflict;

    // rr_ptr holds the last granted index; on a tie the other slot wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (s0_v && s1_v) begin
            if (rr_ptr) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
        end else begin
            gnt0 = s0_v;
            gnt1 = s1_v;
        end
    end

    assign any_gnt       = gnt0 | gnt1;
    assign g_addr        = gnt1 ? s1_a : s0_a;
    assign g_data        = gnt1 ? s1_d : s0_d;
    assign bus.wb0_ready = !s0_v || gnt0;
    assign bus.wb1_ready = !s1_v || gnt1;
    assign take0         = bus.wb0_valid && bus.wb0_ready;
    assign take1         = bus.wb1_valid && bus.wb1_ready;
    assign bus.dbg_rr_ptr = rr_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_v   <= 1'b0;
            s1_v   <= 1'b0;
            s0_a   <= 5'd0;
            s1_a   <= 5'd0;
            s0_d   <= 32'd0;
            s1_d   <= 32'd0;
            rr_ptr <= 1'b1;
        end else begin
            if (take0) begin
                s0_v <= 1'b1;
                s0_a <= bus.wb0_addr;
                s0_d <= bus.wb0_data;
            end else if (gnt0) begin
                s0_v <= 1'b0;
            end
            if (take1) begin
                s1_v <= 1'b1;
                s1_a <= bus.wb1_addr;
                s1_d <= bus.wb1_data;
            end else if (gnt1) begin
                s1_v <= 1'b0;
            end
            if (any_gnt) rr_ptr <= gnt1;
        end
    end

    // Register 0 writes are consumed silently; the write port keeps its last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= 5'd0;
            bus.rf_wdata <= 32'd0;
        end else begin
            bus.rf_we <= any_gnt && (g_addr != 5'd0);
            if (any_gnt && (g_addr != 5'd0)) begin
                bus.rf_waddr <= g_addr;
                bus.rf_wdata <= g_data;
            end
        end
    end

    // A reservation landing on the edge that retires the same register wins (stays pending).
    always_comb begin
        pending_nxt = pending;
        if (bus.rf_we) pending_nxt[bus.rf_waddr] = 1'b0;
        if (bus.rsv_valid && (bus.rsv_addr != 5'd0)) pending_nxt[bus.rsv_addr] = 1'b1;
    end

    assign rsv_conflict = bus.rsv_valid && (bus.rsv_addr != 5'd0) && pending[bus.rsv_addr]
                          && !(bus.rf_we && (bus.rf_waddr == bus.rsv_addr));

    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= 32'd0;
            bus.rsv_err <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (rsv_conflict) bus.rsv_err <= 1'b1;
        end
    end

    assign bus.busy_A = (bus.chk_addrA != 5'd0) && pending[bus.chk_addrA];
    assign bus.busy_B = (bus.chk_addrB != 5'd0) && pending[bus.chk_addrB];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected regfile writes are queued as
// beats are driven and popped by a monitor whenever rf_we is seen.
module tb_regfile_wb_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [36:0] exp_q[$];

  regfile_wb_if bus ();

  regfile_wb_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    check(tag, {36'd0, obs}, {36'd0, exp});
  endtask

  // driver tasks
  task automatic drive_wb0(input logic v, input logic [4:0] a, input logic [31:0] d, input bit expect_write);
    bus.wb0_valid = v;
    bus.wb0_addr  = a;
    bus.wb0_data  = d;
    if (v && expect_write) exp_q.push_back({a, d});
  endtask

  task automatic drive_wb1(input logic v, input logic [4:0] a, input logic [31:0] d, input bit expect_write);
    bus.wb1_valid = v;
    bus.wb1_addr  = a;
    bus.wb1_data  = d;
    if (v && expect_write) exp_q.push_back({a, d});
  endtask

  task automatic drive_rsv(input logic v, input logic [4:0] a);
    bus.rsv_valid = v;
    bus.rsv_addr  = a;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check1("unexpected_write", bus.rf_we, 1'b0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check("wb_write", {bus.rf_waddr, bus.rf_wdata}, e);
      end
    end
  end

  int wr_cnt;
  int first_idx;
  int last_idx;
  logic [31:0] rd;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive_wb0(1'b0, 5'd0, 32'd0, 1'b0);
    drive_wb1(1'b0, 5'd0, 32'd0, 1'b0);
    drive_rsv(1'b0, 5'd0);
    bus.chk_addrA = 5'd9;
    bus.chk_addrB = 5'd0;
    step();
    step();
    reset = 1'b0;

    // reset state
    check1("rst_rf_we", bus.rf_we, 1'b0);
    check("rst_rf_waddr", {32'd0, bus.rf_waddr}, 37'd0);
    check("rst_rf_wdata", {5'd0, bus.rf_wdata}, 37'd0);
    check1("rst_rsv_err", bus.rsv_err, 1'b0);
    check1("rst_busy_A", bus.busy_A, 1'b0);
    check1("rst_wb0_ready", bus.wb0_ready, 1'b1);
    check1("rst_wb1_ready", bus.wb1_ready, 1'b1);
    check1("rst_rr_ptr", bus.dbg_rr_ptr, 1'b1);

    // single write: rf_we only in cycle N+2
    drive_wb0(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    step();
    drive_wb0(1'b0, 5'd0, 32'd0, 1'b0);
    check1("single_n1_we", bus.rf_we, 1'b0);
    step();
    check1("single_n2_we", bus.rf_we, 1'b1);
    step();
    check1("single_n3_we", bus.rf_we, 1'b0);

    // contention: tie after reset grants 0, refill of slot 0 makes the next tie grant 1
    do_reset();
    drive_wb0(1'b1, 5'd3, 32'h11, 1'b1);
    drive_wb1(1'b1, 5'd4, 32'h22, 1'b1);
    step();
    drive_wb1(1'b0, 5'd0, 32'd0, 1'b0);
    drive_wb0(1'b1, 5'd10, 32'hAA, 1'b1);
    check1("tie_ready0_granted", bus.wb0_ready, 1'b1);
    check1("tie_ready1_blocked", bus.wb1_ready, 1'b0);
    step();
    drive_wb0(1'b0, 5'd0, 32'd0, 1'b0);
    check1("tie_rr_ptr_after_g0", bus.dbg_rr_ptr, 1'b0);
    check1("tie2_ready1_granted", bus.wb1_ready, 1'b1);
    check1("tie2_ready0_blocked", bus.wb0_ready, 1'b0);
    step();
    step();
    step();
    check1("tie_idle_we", bus.rf_we, 1'b0);

    // back-to-back unreserved writes to regs 1..8
    wr_cnt = 0;
    first_idx = -1;
    last_idx = -1;
    for (int i = 1; i <= 12; i++) begin
      if (i <= 8) begin
        rd = $urandom;
        drive_wb0(1'b1, 5'(i), rd, 1'b1);
        check1("b2b_ready0", bus.wb0_ready, 1'b1);
      end else begin
        drive_wb0(1'b0, 5'd0, 32'd0, 1'b0);
      end
      step();
      if (bus.rf_we === 1'b1) begin
        wr_cnt++;
        if (first_idx < 0) first_idx = i;
        last_idx = i;
      end
    end
    check("b2b_write_count", 37'(wr_cnt), 37'd8);
    check("b2b_consecutive", 37'(last_idx - first_idx), 37'd7);
    check1("b2b_no_rsv_err", bus.rsv_err, 1'b0);

    // scoreboard: reserve 7, re-reserve while pending, then retire it
    bus.chk_addrA = 5'd7;
    bus.chk_addrB = 5'd8;
    drive_rsv(1'b1, 5'd7);
    step();
    drive_rsv(1'b0, 5'd0);
    check1("sb_busy_A_set", bus.busy_A, 1'b1);
    check1("sb_busy_B_other", bus.busy_B, 1'b0);
    check1("sb_no_err_yet", bus.rsv_err, 1'b0);
    drive_rsv(1'b1, 5'd7);
    step();
    drive_rsv(1'b0, 5'd0);
    check1("sb_rsv_err", bus.rsv_err, 1'b1);
    drive_wb1(1'b1, 5'd7, 32'h7777_0007, 1'b1);
    step();
    drive_wb1(1'b0, 5'd0, 32'd0, 1'b0);
    check1("sb_busy_grant_cycle", bus.busy_A, 1'b1);
    step();
    check1("sb_busy_we_cycle", bus.busy_A, 1'b1);
    step();
    check1("sb_busy_cleared", bus.busy_A, 1'b0);
    check1("sb_rsv_err_sticky", bus.rsv_err, 1'b1);

    // simultaneous set and clear keeps the register pending without an error
    do_reset();
    bus.chk_addrB = 5'd12;
    drive_rsv(1'b1, 5'd12);
    step();
    drive_rsv(1'b0, 5'd0);
    check1("sc_busy_B_set", bus.busy_B, 1'b1);
    drive_wb0(1'b1, 5'd12, 32'h1212_1212, 1'b1);
    step();
    drive_wb0(1'b0, 5'd0, 32'd0, 1'b0);
    step();
    drive_rsv(1'b1, 5'd12);
    step();
    drive_rsv(1'b0, 5'd0);
    check1("sc_still_pending", bus.busy_B, 1'b1);
    check1("sc_no_err", bus.rsv_err, 1'b0);
    drive_wb0(1'b1, 5'd12, 32'h0000_0C0C, 1'b1);
    step();
    drive_wb0(1'b0, 5'd0, 32'd0, 1'b0);
    step();
    step();
    check1("sc_cleared", bus.busy_B, 1'b0);

    // zero register: consumed, never written, never pending
    bus.chk_addrA = 5'd0;
    drive_rsv(1'b1, 5'd0);
    drive_wb1(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    step();
    drive_rsv(1'b0, 5'd0);
    drive_wb1(1'b0, 5'd0, 32'd0, 1'b0);
    check1("zero_busy", bus.busy_A, 1'b0);
    step();
    check1("zero_we_1", bus.rf_we, 1'b0);
    check1("zero_slot_freed", bus.wb1_ready, 1'b1);
    step();
    check1("zero_we_2", bus.rf_we, 1'b0);
    check1("zero_no_err", bus.rsv_err, 1'b0);

    // reset mid-flight discards held entries and pending bits
    bus.chk_addrA = 5'd9;
    bus.chk_addrB = 5'd22;
    drive_rsv(1'b1, 5'd9);
    step();
    drive_rsv(1'b0, 5'd0);
    check1("mid_busy_9_set", bus.busy_A, 1'b1);
    drive_wb0(1'b1, 5'd20, 32'h2020_2020, 1'b0);
    drive_wb1(1'b1, 5'd21, 32'h2121_2121, 1'b0);
    step();
    drive_wb1(1'b0, 5'd0, 32'd0, 1'b0);
    drive_wb0(1'b1, 5'd23, 32'h2323_2323, 1'b0);
    drive_rsv(1'b1, 5'd22);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive_wb0(1'b0, 5'd0, 32'd0, 1'b0);
    drive_rsv(1'b0, 5'd0);
    check1("mid_we_after_rst", bus.rf_we, 1'b0);
    check1("mid_busy_9_clear", bus.busy_A, 1'b0);
    check1("mid_rsv_overridden", bus.busy_B, 1'b0);
    check1("mid_ready0", bus.wb0_ready, 1'b1);
    check1("mid_ready1", bus.wb1_ready, 1'b1);
    step();
    check1("mid_we_later", bus.rf_we, 1'b0);
    step();
    check1("mid_we_later2", bus.rf_we, 1'b0);

    // bounded drain of the expected queue
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) step();
    check("queue_drained", 37'(exp_q.size()), 37'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
